// File: rtl/tl_ul_slave_mem.sv
// rtl/tl_ul_slave_mem.sv - single-outstanding TileLink-UL style word memory slave
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   a_valid, a_channel  A-channel request {opcode,param,size,source,address,data}
//   a_ready             registered; high only while idle
//   backpressureslave   registered; high while a request is in flight
//   d_valid, d_channel  D-channel response {opcode,param,size,source,data}
//   d_error             response error flag, qualified by d_valid
//   d_ready             master accepts the response
module tl_ul_slave_mem #(
    parameter int DEPTH     = 1024,
    parameter int LATENCY   = 2,
    parameter int SIZE_LOG2 = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_valid,
    input  logic [52:0] a_channel,
    output logic        a_ready,
    output logic        backpressureslave,
    output logic        d_valid,
    output logic [42:0] d_channel,
    output logic        d_error,
    input  logic        d_ready
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [2:0] OP_PUT_FULL = 3'd0;
    localparam logic [2:0] OP_GET      = 3'd4;
    localparam logic [2:0] OP_ACK      = 3'd0;
    localparam logic [2:0] OP_ACK_DATA = 3'd1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t         state;
    logic [CW-1:0]  counter;
    logic [2:0]     req_opcode;
    logic [2:0]     req_size;
    logic [1:0]     req_source;
    logic [9:0]     req_addr;
    logic [31:0]    req_data;

    logic [31:0]    mem [DEPTH];

    logic           req_err;
    logic           exec;
    logic           mem_wr;
    logic [31:0]    rd_data;
    logic [2:0]     rsp_opcode;
    logic [31:0]    rsp_data;

    // The param field carries nothing for this slave.
    logic           unused_param;
    assign unused_param = ^a_channel[49:47];

    always_comb begin
        req_err = 1'b0;
        if (req_opcode != OP_PUT_FULL && req_opcode != OP_GET) req_err = 1'b1;
        if ({22'd0, req_addr} >= 32'(DEPTH))                    req_err = 1'b1;
        if (req_size != 3'(SIZE_LOG2))                          req_err = 1'b1;
    end

    // Execute cycle: last WAIT cycle, where the array is read or written.
    assign exec       = (state == WAIT) && (counter == '0);
    assign mem_wr     = exec && !reset && (req_opcode == OP_PUT_FULL) && !req_err;
    assign rd_data    = mem[req_addr[AW-1:0]];
    assign rsp_opcode = (req_opcode == OP_GET) ? OP_ACK_DATA : OP_ACK;
    assign rsp_data   = ((req_opcode == OP_GET) && !req_err) ? rd_data : 32'd0;

    // Array has no reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[req_addr[AW-1:0]] <= req_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            a_ready           <= 1'b1;
            backpressureslave <= 1'b0;
            d_valid           <= 1'b0;
            d_channel         <= '0;
            d_error           <= 1'b0;
            counter           <= '0;
            req_opcode        <= '0;
            req_size          <= '0;
            req_source        <= '0;
            req_addr          <= '0;
            req_data          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (a_valid && a_ready) begin
                        req_opcode        <= a_channel[52:50];
                        req_size          <= a_channel[46:44];
                        req_source        <= a_channel[43:42];
                        req_addr          <= a_channel[41:32];
                        req_data          <= a_channel[31:0];
                        counter           <= CW'(LATENCY - 1);
                        a_ready           <= 1'b0;
                        backpressureslave <= 1'b1;
                        state             <= WAIT;
                    end
                end
                WAIT: begin
                    if (counter != '0) begin
                        counter <= counter - CW'(1);
                    end else begin
                        d_valid   <= 1'b1;
                        d_error   <= req_err;
                        d_channel <= {rsp_opcode, 3'd0, req_size, req_source, rsp_data};
                        state     <= RESP;
                    end
                end
                RESP: begin
                    // Handshake cycle does not accept; a_ready rises on this edge.
                    if (d_ready) begin
                        d_valid           <= 1'b0;
                        d_error           <= 1'b0;
                        backpressureslave <= 1'b0;
                        a_ready           <= 1'b1;
                        state             <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tl_ul_slave_mem.sv
// tb/tb_tl_ul_slave_mem.sv - randomized self-checking bench for tl_ul_slave_mem
module tb_tl_ul_slave_mem;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_valid   [2];
    logic [52:0] a_channel [2];
    logic        a_ready   [2];
    logic        bp        [2];
    logic        d_valid   [2];
    logic [42:0] d_channel [2];
    logic        d_error   [2];
    logic        d_ready   [2];

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem_m [2][1024];
    int          wq [$];

    always #5 clk = ~clk;

    tl_ul_slave_mem #(.DEPTH(512), .LATENCY(2), .SIZE_LOG2(5)) dut0 (
        .clk(clk), .reset(reset),
        .a_valid(a_valid[0]), .a_channel(a_channel[0]), .a_ready(a_ready[0]),
        .backpressureslave(bp[0]), .d_valid(d_valid[0]), .d_channel(d_channel[0]),
        .d_error(d_error[0]), .d_ready(d_ready[0])
    );

    tl_ul_slave_mem #(.DEPTH(1024), .LATENCY(1), .SIZE_LOG2(5)) dut1 (
        .clk(clk), .reset(reset),
        .a_valid(a_valid[1]), .a_channel(a_channel[1]), .a_ready(a_ready[1]),
        .backpressureslave(bp[1]), .d_valid(d_valid[1]), .d_channel(d_channel[1]),
        .d_error(d_error[1]), .d_ready(d_ready[1])
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input int u);
        return (u == 0) ? 2 : 1;
    endfunction

    function automatic int depth_of(input int u);
        return (u == 0) ? 512 : 1024;
    endfunction

    task automatic check_reset_vals(input int u, input string tag);
        check_eq({tag, "_a_ready"}, 64'(a_ready[u]), 64'd1);
        check_eq({tag, "_bp"}, 64'(bp[u]), 64'd0);
        check_eq({tag, "_d_valid"}, 64'(d_valid[u]), 64'd0);
        check_eq({tag, "_d_channel"}, 64'(d_channel[u]), 64'd0);
        check_eq({tag, "_d_error"}, 64'(d_error[u]), 64'd0);
    endtask

    // One full request/response; hold = cycles d_ready stays low after d_valid.
    task automatic txn(input int u, input logic [2:0] op, input logic [2:0] sz,
                       input logic [1:0] src, input logic [9:0] addr,
                       input logic [31:0] data, input int hold, input bit intrude);
        bit          err;
        logic [2:0]  e_op;
        logic [31:0] e_data;
        logic [42:0] e_d;
        int          lat;

        err    = !(op == 3'd0 || op == 3'd4) || (int'(addr) >= depth_of(u)) || (sz != 3'd5);
        e_op   = (op == 3'd4) ? 3'd1 : 3'd0;
        e_data = (op == 3'd4 && !err) ? mem_m[u][addr] : 32'd0;
        e_d    = {e_op, 3'd0, sz, src, e_data};
        if (op == 3'd0 && !err) begin
            mem_m[u][addr] = data;
            if (u == 0) wq.push_back(int'(addr));
        end

        @(negedge clk);
        check_eq("a_ready_idle", 64'(a_ready[u]), 64'd1);
        a_valid[u]   = 1'b1;
        a_channel[u] = {op, 3'd0, sz, src, addr, data};
        d_ready[u]   = (hold == 0);
        @(posedge clk); #1;
        a_valid[u]   = 1'b0;
        a_channel[u] = $urandom;
        check_eq("a_ready_busy", 64'(a_ready[u]), 64'd0);
        check_eq("bp_busy", 64'(bp[u]), 64'd1);

        lat = 0;
        do begin
            if (lat > 0 || lat_of(u) > 1) check_eq("d_valid_early", 64'(d_valid[u]), 64'd0);
            @(posedge clk); #1;
            lat++;
        end while (!d_valid[u] && lat < 20);
        check_eq("latency", 64'(lat), 64'(lat_of(u)));
        check_eq("d_channel", 64'(d_channel[u]), 64'(e_d));
        check_eq("d_error", 64'(d_error[u]), 64'(err));

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            a_valid[u]   = intrude && (i == 1);
            a_channel[u] = {3'd4, 3'd0, 3'd5, 2'd3, 10'h001, 32'd0};
            @(posedge clk); #1;
            check_eq("hold_d_valid", 64'(d_valid[u]), 64'd1);
            check_eq("hold_d_channel", 64'(d_channel[u]), 64'(e_d));
            check_eq("hold_d_error", 64'(d_error[u]), 64'(err));
            check_eq("hold_bp", 64'(bp[u]), 64'd1);
            check_eq("hold_a_ready", 64'(a_ready[u]), 64'd0);
        end
        @(negedge clk);
        a_valid[u] = 1'b0;
        d_ready[u] = 1'b1;
        @(posedge clk); #1;
        check_eq("done_d_valid", 64'(d_valid[u]), 64'd0);
        check_eq("done_d_error", 64'(d_error[u]), 64'd0);
        check_eq("done_a_ready", 64'(a_ready[u]), 64'd1);
        check_eq("done_bp", 64'(bp[u]), 64'd0);
        if (intrude) begin
            @(posedge clk); #1;
            check_eq("ignored_d_valid", 64'(d_valid[u]), 64'd0);
            check_eq("ignored_a_ready", 64'(a_ready[u]), 64'd1);
        end
        d_ready[u] = 1'b0;
    endtask

    // Put accepted, then reset before it executes: write must be lost.
    task automatic reset_mid(input int u, input logic [9:0] addr, input logic [31:0] data);
        @(negedge clk);
        a_valid[u]   = 1'b1;
        a_channel[u] = {3'd0, 3'd0, 3'd5, 2'd0, addr, data};
        @(posedge clk); #1;
        a_valid[u] = 1'b0;
        check_eq("rm_bp", 64'(bp[u]), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_vals(u, "rm");
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [2:0] bad_ops [6];
        bad_ops = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
        for (int u = 0; u < 2; u++) begin
            a_valid[u] = 1'b0; a_channel[u] = '0; d_ready[u] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals(0, "rst0");
        check_reset_vals(1, "rst1");
        @(negedge clk);
        reset = 1'b0;

        txn(0, 3'd0, 3'd5, 2'd1, 10'h010, 32'hDEADBEEF, 0, 0);
        txn(0, 3'd4, 3'd5, 2'd2, 10'h010, 32'h0, 0, 0);
        txn(0, 3'd4, 3'd5, 2'd3, 10'h010, 32'h0, 3, 1);
        txn(0, 3'd2, 3'd5, 2'd0, 10'h010, 32'h55555555, 0, 0);
        txn(0, 3'd4, 3'd5, 2'd0, 10'h010, 32'h0, 0, 0);
        txn(0, 3'd0, 3'd5, 2'd1, 10'h100, 32'hA5A5_0100, 0, 0);
        txn(0, 3'd4, 3'd5, 2'd1, 10'h300, 32'h0, 0, 0);
        txn(0, 3'd0, 3'd5, 2'd1, 10'h300, 32'h0BAD_0300, 0, 0);
        txn(0, 3'd4, 3'd5, 2'd1, 10'h100, 32'h0, 0, 0);
        txn(0, 3'd0, 3'd5, 2'd2, 10'h020, 32'hCAFEF00D, 0, 0);
        txn(0, 3'd0, 3'd2, 2'd2, 10'h020, 32'h00000001, 0, 0);
        txn(0, 3'd4, 3'd5, 2'd2, 10'h020, 32'h0, 0, 0);
        reset_mid(0, 10'h020, 32'h12345678);
        txn(0, 3'd4, 3'd5, 2'd3, 10'h020, 32'h0, 0, 0);

        for (int k = 0; k < 40; k++) begin
            int          r;
            logic [2:0]  op;
            logic [2:0]  sz;
            logic [9:0]  addr;
            r    = $urandom_range(0, 9);
            sz   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd5;
            addr = 10'($urandom_range(0, 1023));
            if (r < 4) begin
                op = 3'd0;
            end else if (r < 8) begin
                op = 3'd4;
                if (r[0] && wq.size() > 0) addr = 10'(wq[$urandom_range(0, wq.size() - 1)]);
                else addr = 10'(512 + $urandom_range(0, 511));
            end else begin
                op = bad_ops[$urandom_range(0, 5)];
            end
            txn(0, op, sz, 2'($urandom_range(0, 3)), addr, $urandom,
                $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        txn(1, 3'd0, 3'd5, 2'd1, 10'h300, 32'h1357_9BDF, 0, 0);
        txn(1, 3'd4, 3'd5, 2'd2, 10'h300, 32'h0, 0, 0);
        txn(1, 3'd4, 3'd5, 2'd3, 10'h300, 32'h0, 2, 1);
        txn(1, 3'd6, 3'd5, 2'd0, 10'h300, 32'hFFFF_FFFF, 0, 0);
        txn(1, 3'd4, 3'd5, 2'd0, 10'h300, 32'h0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
